// File: rtl/zone_arm_controller.sv
// zone_arm_controller
//
// Multi-zone arm/disarm controller for the security-system control path. Conditions the raw
// arm/disarm switches (2-FF synchroniser + debounce) and the zone trip inputs (2-FF
// synchroniser only), then runs a DISARMED -> EXIT_DELAY -> ARMED -> ENTRY_DELAY -> ALARM state
// machine. Trips are checked against a zone mask captured when an arm request is accepted, and
// every enabled zone that trips is recorded in a sticky attribution vector.
//
// Parameters
//   NUM_ZONES        number of sensor zones (1..32)
//   DEBOUNCE_CYCLES  consecutive disagreeing cycles needed to accept a switch change (>=1)
//   EXIT_DELAY       cycles spent in EXIT_DELAY before arming completes (>=1)
//   ENTRY_DELAY      cycles spent in ENTRY_DELAY before the alarm fires (>=1)
//
// Ports
//   clk            system clock, all state updates on posedge
//   resetN         asynchronous active-low reset
//   armSwitch      raw asynchronous arm switch
//   disarmSwitch   raw asynchronous disarm switch
//   zoneEnable     per-zone enable mask, sampled only when an arm request is accepted
//   zoneTrip       raw asynchronous per-zone trip levels (1 = tripped)
//   systemArmed    high in ARMED, ENTRY_DELAY, ALARM
//   disarmedState  high only in DISARMED
//   exitPending    high only in EXIT_DELAY
//   entryPending   high only in ENTRY_DELAY
//   alarmActive    high only in ALARM
//   alarmZones     sticky record of enabled zones that tripped since the last accepted arm
//   stateOut       encoded state: 0 DISARMED, 1 EXIT_DELAY, 2 ARMED, 3 ENTRY_DELAY, 4 ALARM
//
// All outputs are registered; they are loaded from the next-state value so that they always
// equal a decode of the state register, with no combinational path from any input.

module zone_arm_controller #(
  parameter int unsigned NUM_ZONES       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned EXIT_DELAY      = 100,
  parameter int unsigned ENTRY_DELAY     = 50
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 armSwitch,
  input  logic                 disarmSwitch,
  input  logic [NUM_ZONES-1:0] zoneEnable,
  input  logic [NUM_ZONES-1:0] zoneTrip,
  output logic                 systemArmed,
  output logic                 disarmedState,
  output logic                 exitPending,
  output logic                 entryPending,
  output logic                 alarmActive,
  output logic [NUM_ZONES-1:0] alarmZones,
  output logic [2:0]           stateOut
);

  // ---------------------------------------------------------------------------------------------
  // Sizing
  // ---------------------------------------------------------------------------------------------
  localparam int unsigned MaxDelay = (EXIT_DELAY > ENTRY_DELAY) ? EXIT_DELAY : ENTRY_DELAY;
  localparam int unsigned CntW     = $clog2(MaxDelay + 1);
  localparam int unsigned DbW      = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [CntW-1:0] ExitLoad  = CntW'(EXIT_DELAY - 1);
  localparam logic [CntW-1:0] EntryLoad = CntW'(ENTRY_DELAY - 1);
  // Debounce count value at which the next disagreeing cycle completes the required run.
  localparam logic [DbW-1:0]  DbLast    = DbW'(DEBOUNCE_CYCLES - 1);

  // Switch vector bit positions.
  localparam int unsigned SwArm    = 0;
  localparam int unsigned SwDisarm = 1;

  typedef enum logic [2:0] {
    StDisarmed = 3'd0,
    StExit     = 3'd1,
    StArmed    = 3'd2,
    StEntry    = 3'd3,
    StAlarm    = 3'd4
  } state_e;

  // ---------------------------------------------------------------------------------------------
  // Switch conditioning: 2-FF synchroniser followed by a debouncer per switch
  // ---------------------------------------------------------------------------------------------
  logic [1:0]     sw_meta_q;
  logic [1:0]     sw_sync_q;
  logic [1:0]     sw_deb_q;
  logic [DbW-1:0] db_cnt_q [2];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      sw_deb_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sw_meta_q <= {disarmSwitch, armSwitch};
      sw_sync_q <= sw_meta_q;
      for (int i = 0; i < 2; i++) begin
        if (sw_sync_q[i] == sw_deb_q[i]) begin
          // Any agreement restarts the stability run.
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbLast) begin
          sw_deb_q[i] <= sw_sync_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Zone trip synchroniser (trips are level inputs and are not debounced)
  // ---------------------------------------------------------------------------------------------
  logic [NUM_ZONES-1:0] trip_meta_q;
  logic [NUM_ZONES-1:0] trip_sync_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      trip_meta_q <= '0;
      trip_sync_q <= '0;
    end else begin
      trip_meta_q <= zoneTrip;
      trip_sync_q <= trip_meta_q;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------------------------
  logic arm_deb;
  logic disarm_deb;
  logic arm_prev_q;
  logic arm_req;
  logic disarm_req;

  assign arm_deb    = sw_deb_q[SwArm];
  assign disarm_deb = sw_deb_q[SwDisarm];

  // Arm is edge-triggered so a held switch cannot re-arm after a disarm; disarm is a level.
  // With both switches debounced high neither request exists.
  assign arm_req    = arm_deb & ~arm_prev_q & ~disarm_deb;
  assign disarm_req = disarm_deb & ~arm_deb;

  // ---------------------------------------------------------------------------------------------
  // State machine next-state logic
  // ---------------------------------------------------------------------------------------------
  state_e               state_q;
  state_e               state_d;
  logic [CntW-1:0]      cnt_q;
  logic [CntW-1:0]      cnt_d;
  logic [NUM_ZONES-1:0] mask_q;
  logic [NUM_ZONES-1:0] mask_d;
  logic [NUM_ZONES-1:0] zones_d;
  logic [NUM_ZONES-1:0] trip_hit;

  assign trip_hit = trip_sync_q & mask_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    zones_d = alarmZones;

    case (state_q)
      StDisarmed: begin
        if (arm_req && (zoneEnable != '0)) begin
          mask_d  = zoneEnable;
          zones_d = '0;
          cnt_d   = ExitLoad;
          state_d = StExit;
        end
      end

      StExit: begin
        // Trips are deliberately ignored while the occupant is leaving.
        if (disarm_req) begin
          state_d = StDisarmed;
        end else if (cnt_q == '0) begin
          state_d = StArmed;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StArmed: begin
        if (disarm_req) begin
          state_d = StDisarmed;
        end else if (trip_hit != '0) begin
          zones_d = alarmZones | trip_hit;
          cnt_d   = EntryLoad;
          state_d = StEntry;
        end
      end

      StEntry: begin
        // Disarm wins outright: a simultaneous trip is not recorded.
        if (disarm_req) begin
          state_d = StDisarmed;
        end else begin
          zones_d = alarmZones | trip_hit;
          if (cnt_q == '0) begin
            state_d = StAlarm;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end

      StAlarm: begin
        if (disarm_req) begin
          state_d = StDisarmed;
        end else begin
          zones_d = alarmZones | trip_hit;
        end
      end

      default: begin
        state_d = StDisarmed;
      end
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // State register and registered outputs
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= StDisarmed;
      cnt_q         <= '0;
      mask_q        <= '0;
      arm_prev_q    <= 1'b0;
      alarmZones    <= '0;
      systemArmed   <= 1'b0;
      disarmedState <= 1'b1;
      exitPending   <= 1'b0;
      entryPending  <= 1'b0;
      alarmActive   <= 1'b0;
      stateOut      <= 3'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      arm_prev_q    <= arm_deb;
      alarmZones    <= zones_d;
      systemArmed   <= (state_d == StArmed) || (state_d == StEntry) || (state_d == StAlarm);
      disarmedState <= (state_d == StDisarmed);
      exitPending   <= (state_d == StExit);
      entryPending  <= (state_d == StEntry);
      alarmActive   <= (state_d == StAlarm);
      stateOut      <= state_d;
    end
  end

endmodule

// File: tb/tb_zone_arm_controller.sv
// tb_zone_arm_controller
//
// Scoreboard bench for zone_arm_controller (NUM_ZONES=4, DEBOUNCE_CYCLES=4, EXIT_DELAY=8,
// ENTRY_DELAY=6). Stimulus pushes each expected output transition (full output word plus, where
// it matters, how many cycles the previous word must have lasted); a monitor pops one entry
// every time the DUT output word changes. Asynchronous reset is checked 1 time unit after
// resetN falls, while the clock is high.

module tb_zone_arm_controller;

  localparam int unsigned Zones = 4;

  localparam logic [2:0] SDis   = 3'd0;
  localparam logic [2:0] SExit  = 3'd1;
  localparam logic [2:0] SArmed = 3'd2;
  localparam logic [2:0] SEntry = 3'd3;
  localparam logic [2:0] SAlarm = 3'd4;

  logic             clk = 1'b0;
  logic             resetN = 1'b1;
  logic             armSwitch = 1'b0;
  logic             disarmSwitch = 1'b0;
  logic [Zones-1:0] zoneEnable = '0;
  logic [Zones-1:0] zoneTrip = '0;
  logic             systemArmed;
  logic             disarmedState;
  logic             exitPending;
  logic             entryPending;
  logic             alarmActive;
  logic [Zones-1:0] alarmZones;
  logic [2:0]       stateOut;

  zone_arm_controller #(
    .NUM_ZONES      (4),
    .DEBOUNCE_CYCLES(4),
    .EXIT_DELAY     (8),
    .ENTRY_DELAY    (6)
  ) dut (
    .clk          (clk),
    .resetN       (resetN),
    .armSwitch    (armSwitch),
    .disarmSwitch (disarmSwitch),
    .zoneEnable   (zoneEnable),
    .zoneTrip     (zoneTrip),
    .systemArmed  (systemArmed),
    .disarmedState(disarmedState),
    .exitPending  (exitPending),
    .entryPending (entryPending),
    .alarmActive  (alarmActive),
    .alarmZones   (alarmZones),
    .stateOut     (stateOut)
  );

  always #5 clk = ~clk;

  // Output word: {systemArmed, disarmedState, exitPending, entryPending, alarmActive, zones, st}
  function automatic logic [11:0] mk(input logic [2:0] st, input logic [3:0] z);
    logic sys, dis, ex, en, al;
    dis = (st == SDis);
    ex  = (st == SExit);
    en  = (st == SEntry);
    al  = (st == SAlarm);
    sys = (st == SArmed) || (st == SEntry) || (st == SAlarm);
    return {sys, dis, ex, en, al, z, st};
  endfunction

  typedef struct {
    string       name;
    logic [11:0] word;
    int          dwell;  // required cycles the previous word lasted; -1 = don't care
  } exp_t;

  exp_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int stalls      = 0;
  int stalls_seen = 0;
  int stall_left  = 0;

  logic [11:0] last_w = 'x;
  logic [11:0] cur_w;
  int          dwell = 0;
  exp_t        e;

  function automatic logic [11:0] out_word();
    return {systemArmed, disarmedState, exitPending, entryPending, alarmActive, alarmZones,
            stateOut};
  endfunction

  // Monitor: falling clock edge -> transition check; falling resetN (clock high) -> async check.
  always @(negedge clk or negedge resetN) begin
    if (clk) begin
      #1;
      cur_w = out_word();
      vectors++;
      if (cur_w !== mk(SDis, 4'b0000)) begin
        miscompares++;
        $display("FAIL async_reset: outputs %h, required %h", cur_w, mk(SDis, 4'b0000));
      end
    end else begin
      if (stalls != stalls_seen) begin
        vectors++;
        miscompares++;
        $display("FAIL drain_timeout: %0d transitions still pending, required 0", stall_left);
        stalls_seen = stalls;
      end
      cur_w = out_word();
      if (cur_w !== last_w) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_change: outputs %h, required %h (unchanged)", cur_w, last_w);
        end else begin
          e = exp_q.pop_front();
          vectors++;
          if (cur_w !== e.word) begin
            miscompares++;
            $display("FAIL %s: outputs %h, required %h", e.name, cur_w, e.word);
          end
          if (e.dwell >= 0) begin
            vectors++;
            if (dwell != e.dwell) begin
              miscompares++;
              $display("FAIL %s_dwell: previous state lasted %0d cycles, required %0d",
                       e.name, dwell, e.dwell);
            end
          end
        end
        last_w = cur_w;
        dwell  = 1;
      end else begin
        dwell++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input string name, input logic [2:0] st, input logic [3:0] z,
                      input int dw);
    exp_t x;
    x.name  = name;
    x.word  = mk(st, z);
    x.dwell = dw;
    exp_q.push_back(x);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      stall_left = exp_q.size();
      exp_q.delete();
      stalls++;
    end
  endtask

  // Arm from DISARMED with zones cleared; exit delay must last exactly 8 cycles.
  task automatic arm_cycle(input string tag);
    push({tag, "_exit"}, SExit, 4'b0000, -1);
    push({tag, "_armed"}, SArmed, 4'b0000, 8);
    armSwitch = 1'b1;
    wait_drain(40);
    armSwitch = 1'b0;
    tick(8);
  endtask

  initial begin
    push("reset", SDis, 4'b0000, -1);
    #7 resetN = 1'b0;
    tick(3);
    resetN = 1'b1;
    tick(5);

    // Arm glitch shorter than the debounce run: nothing happens.
    armSwitch = 1'b1;
    tick(3);
    armSwitch = 1'b0;
    tick(8);

    // Arm with mask 0101.
    zoneEnable = 4'b0101;
    arm_cycle("arm1");

    // Masked-out trip, then an enabled trip running through to ALARM.
    zoneTrip = 4'b0010;
    tick(2);
    zoneTrip = 4'b0000;
    tick(6);
    push("entry1", SEntry, 4'b0100, -1);
    push("alarm1", SAlarm, 4'b0100, 6);
    zoneTrip = 4'b0100;
    tick(2);
    zoneTrip = 4'b0000;
    wait_drain(30);
    tick(3);

    // Disarm from ALARM keeps the attribution.
    push("disarm_alarm", SDis, 4'b0100, -1);
    disarmSwitch = 1'b1;
    wait_drain(20);
    disarmSwitch = 1'b0;
    tick(8);

    // Re-arm clears the attribution.
    arm_cycle("rearm1");

    // Entry delay aborted by disarm: trip and disarm switch rise together, so the entry
    // state lasts DEBOUNCE_CYCLES cycles and ALARM is never reached.
    push("entry2", SEntry, 4'b0100, -1);
    push("disarm_entry", SDis, 4'b0100, 4);
    zoneTrip = 4'b0100;
    disarmSwitch = 1'b1;
    tick(2);
    zoneTrip = 4'b0000;
    wait_drain(20);
    disarmSwitch = 1'b0;
    tick(8);

    arm_cycle("rearm2");

    // Both switches high from ARMED: held.
    armSwitch = 1'b1;
    disarmSwitch = 1'b1;
    tick(20);
    armSwitch = 1'b0;
    disarmSwitch = 1'b0;
    tick(8);

    push("disarm_armed", SDis, 4'b0000, -1);
    disarmSwitch = 1'b1;
    wait_drain(20);
    disarmSwitch = 1'b0;
    tick(8);

    // Both switches high from DISARMED: held.
    armSwitch = 1'b1;
    disarmSwitch = 1'b1;
    tick(20);
    armSwitch = 1'b0;
    disarmSwitch = 1'b0;
    tick(8);

    // Reset in the middle of EXIT_DELAY.
    push("exit3", SExit, 4'b0000, -1);
    armSwitch = 1'b1;
    wait_drain(20);
    tick(3);
    push("reset_exit", SDis, 4'b0000, -1);
    #1 resetN = 1'b0;
    armSwitch = 1'b0;
    tick(3);
    resetN = 1'b1;
    tick(8);

    // Reset in the middle of ALARM.
    arm_cycle("arm4");
    push("entry4", SEntry, 4'b0001, -1);
    push("alarm4", SAlarm, 4'b0001, 6);
    zoneTrip = 4'b0001;
    tick(2);
    zoneTrip = 4'b0000;
    wait_drain(30);
    tick(2);
    push("reset_alarm", SDis, 4'b0000, -1);
    #1 resetN = 1'b0;
    tick(3);
    resetN = 1'b1;
    tick(8);

    // Arm request with an empty mask is ignored.
    zoneEnable = 4'b0000;
    armSwitch = 1'b1;
    tick(15);
    armSwitch = 1'b0;
    tick(8);

    wait_drain(5);
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

endmodule
